// File: rtl/fetch_unit.sv
// fetch_unit: single-issue instruction fetch stage.
// Presents PC_F to a synchronous memory, pairs the returned word with PC_D,
// and handles decode stalls and execute-stage redirects.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned redirect -> FAULT).
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Stall_En,
  input  logic        Redirect_E,
  input  logic [31:0] PC_Target_E,
  input  logic [31:0] Instr_Raw,
  output logic [31:0] PC_F,
  output logic [31:0] PC_D,
  output logic [31:0] PC_Plus4_D,
  output logic [31:0] Instr_D,
  output logic        Valid_D,
  output logic        Fetch_Fault
);

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [2:0] {
    S_BOOT   = 3'd0,
    S_RUN    = 3'd1,
    S_HOLD   = 3'd2,
    S_SQUASH = 3'd3,
    S_FAULT  = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_HOLD   = 2'd2,
    S_SQUASH = 2'd3
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] pc_d_q, pc_d_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] pc_f_plus4;
  logic [31:0] target_aligned;
  logic        target_misaligned;

  assign pc_f_plus4        = pc_f_q + 32'd4;
  assign target_aligned    = PC_Target_E & 32'hFFFF_FFFC;
  assign target_misaligned = (PC_Target_E[1:0] != 2'b00);

  // State and PC registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_BOOT;
      pc_f_q       <= RESET_PC;
      pc_d_q       <= RESET_PC;
      hold_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_f_q       <= pc_f_d;
      pc_d_q       <= pc_d_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  // Next-state and PC update: redirect beats stall beats advance
  always_comb begin
    state_d      = state_q;
    pc_f_d       = pc_f_q;
    pc_d_d       = pc_d_q;
    hold_instr_d = hold_instr_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    if (state_q == S_FAULT) begin
      state_d = S_FAULT;
    end else if (Redirect_E) begin
      if (target_misaligned) begin
        state_d = S_FAULT;
        pc_f_d  = PC_Target_E;
      end else begin
        state_d = S_SQUASH;
        pc_f_d  = target_aligned;
      end
    end else begin
`else
    if (Redirect_E) begin
      state_d = S_SQUASH;
      pc_f_d  = target_aligned;
    end else begin
`endif
      case (state_q)
        S_RUN: begin
          if (Stall_En) begin
            // Memory output moves on next cycle; keep the word decode is using
            state_d      = S_HOLD;
            hold_instr_d = Instr_Raw;
          end else begin
            pc_d_d = pc_f_q;
            pc_f_d = pc_f_plus4;
          end
        end
        S_HOLD: begin
          if (!Stall_En) begin
            state_d = S_RUN;
            pc_d_d  = pc_f_q;
            pc_f_d  = pc_f_plus4;
          end
        end
        default: begin
          // BOOT and SQUASH advance unconditionally; stall is ignored
          state_d = S_RUN;
          pc_d_d  = pc_f_q;
          pc_f_d  = pc_f_plus4;
        end
      endcase
    end
  end

  // Decode-side outputs derived from current state
  always_comb begin
    Instr_D = NOP_INSTR;
    Valid_D = 1'b0;
    case (state_q)
      S_RUN: begin
        Instr_D = Instr_Raw;
        Valid_D = 1'b1;
      end
      S_HOLD: begin
        Instr_D = hold_instr_q;
        Valid_D = 1'b1;
      end
      default: begin
        Instr_D = NOP_INSTR;
        Valid_D = 1'b0;
      end
    endcase
  end

  assign PC_F       = pc_f_q;
  assign PC_D       = pc_d_q;
  assign PC_Plus4_D = pc_d_q + 32'd4;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign Fetch_Fault = (state_q == S_FAULT);
`else
  assign Fetch_Fault = 1'b0 & target_misaligned;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC_F value after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013: addi x0,x0,0, driven on Instr_D when invalid.
REQ-003 CLK  in  1  single clock, all state updates on rising edge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 Stall_En  in  1  hazard unit: hold decode contents and PC.
REQ-006 Redirect_E  in  1  taken branch/jump resolved in execute.
REQ-007 PC_Target_E  in  32  redirect target address.
REQ-008 Instr_Raw  in  32  memory port-B output; data for the address presented one cycle earlier.
REQ-009 PC_F  out  32  fetch address to memory port B (registered).
REQ-010 PC_D  out  32  address of the instruction on Instr_D (registered).
REQ-011 PC_Plus4_D  out  32  PC_D + 4, modulo 2^32.
REQ-012 Instr_D  out  32  instruction to decode.
REQ-013 Valid_D  out  1  Instr_D is a real instruction.
REQ-014 Fetch_Fault  out  1  misaligned redirect seen (see Configuration).

Function
REQ-015 States SHALL be BOOT, RUN, HOLD, SQUASH, plus FAULT when the Configuration macro is defined.
REQ-016 Priority at each edge SHALL be RST > Redirect_E > Stall_En > advance.
REQ-017 BOOT, no redirect: PC_D<=PC_F, PC_F<=PC_F+4, go to RUN; Stall_En ignored.
REQ-018 RUN/HOLD/BOOT/SQUASH with Redirect_E: PC_F<=PC_Target_E (aligned per REQ-029/030), PC_D unchanged, go to SQUASH.
REQ-019 RUN with Stall_En: PC_F and PC_D held, Hold_Instr<=Instr_Raw, go to HOLD.
REQ-020 RUN, no stall: PC_D<=PC_F, PC_F<=PC_F+4, stay RUN.
REQ-021 HOLD with Stall_En: everything held, stay HOLD; no stall: PC_D<=PC_F, PC_F<=PC_F+4, go to RUN.
REQ-022 SQUASH, no redirect: PC_D<=PC_F, PC_F<=PC_F+4, go to RUN; Stall_En ignored.
REQ-023 Instr_D SHALL be Instr_Raw in RUN, Hold_Instr in HOLD, and NOP_INSTR in BOOT/SQUASH/FAULT.
REQ-024 Valid_D SHALL be 1 in RUN/HOLD and 0 otherwise.
REQ-025 PC arithmetic SHALL be 32-bit wrap-around: 32'hFFFF_FFFC+4 = 32'h0000_0000.
REQ-026 Latency: the redirect edge is followed by exactly one bubble cycle; the instruction at the target is on Instr_D two cycles after the redirect edge.
REQ-027 Instr_Raw SHALL never be registered into PC_D or the decision logic; it is captured only into Hold_Instr.

Reset
REQ-028 On RST at an edge: state=BOOT, PC_F=RESET_PC, PC_D=RESET_PC, Hold_Instr=NOP_INSTR, Fetch_Fault=0, Valid_D=0, Instr_D=NOP_INSTR; applies from any state, including HOLD and FAULT.

Configuration
REQ-029 With FETCH_MISALIGN_CHECK_EN defined: a redirect with PC_Target_E[1:0]!=0 SHALL go to FAULT, load PC_F with PC_Target_E, and set Fetch_Fault=1.
REQ-029a In FAULT, PC_F/PC_D SHALL freeze and Valid_D=0, and FAULT SHALL be left only by reset.
REQ-030 Without FETCH_MISALIGN_CHECK_EN: PC_F<={PC_Target_E[31:2],2'b00}, FAULT SHALL not exist, and Fetch_Fault SHALL be tied 0.

Verification
REQ-031 Reset then 3 free cycles, mem[0]=A, mem[4]=B -> Valid_D 0,1,1; Instr_D NOP,A,B; PC_D 0,0,4.
REQ-032 Stall_En high for 3 cycles while Instr_D=B (PC_D=4) -> Instr_D=B, PC_D=4, PC_F=8 throughout; the cycle after release shows mem[8] with PC_D=8.
REQ-033 Redirect_E with PC_Target_E=0x40 while PC_F=0x10 -> next cycle Valid_D=0, PC_F=0x40; following cycle Instr_D=mem[0x40], PC_D=0x40.
REQ-034 Redirect_E and Stall_En together -> redirect wins: SQUASH entered, Hold_Instr unused.
REQ-035 RESET_PC=32'hFFFF_FFFC, run 2 cycles -> PC_D=0xFFFF_FFFC then 0x0, PC_Plus4_D=0x0 then 0x4.
REQ-036 PC_Target_E=0x42 -> with macro: Fetch_Fault=1, Valid_D=0 until RST; without macro: PC_F=0x40, Fetch_Fault=0.
